keypad_scanner: RTL and testbench

Parametrised matrix-keypad scanner with frame-based debounce, press/release events, multi-key rejection and optional auto-repeat. Drives active-low rows one at a time, samples active-low columns through a synchroniser, and emits one code per debounced press. It sits between the board keypad pins and the calculator/stopwatch command decoder, which consumes `key_valid`/`key_code`.

---
 rtl/keypad_scanner.sv | 197 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: matrix keypad scanner with frame-based debounce, press and
// release events, multi-key rejection and optional auto-repeat. Rows are
// driven low one at a time. Columns are synchronised, snapshotted per row,
// and the snapshot is evaluated once per complete frame.
module keypad_scanner #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SETTLE_CYC      = 4,
  parameter int DEBOUNCE_FRAMES = 31250,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 1562500,
  parameter int REPEAT_PERIOD   = 312500,
  parameter int KW              = $clog2(ROWS*COLS)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [ROWS-1:0] row,
  input  logic [COLS-1:0] col,
  output logic [KW-1:0]   key_code,
  output logic            key_valid,
  output logic            key_release,
  output logic            key_held,
  output logic            multi_key
);

  localparam int NK   = ROWS * COLS;
  localparam int RW   = $clog2(ROWS);
  localparam int SW   = $clog2(SETTLE_CYC);
  localparam int M1   = (DEBOUNCE_FRAMES > REPEAT_DELAY) ? DEBOUNCE_FRAMES : REPEAT_DELAY;
  localparam int MAXC = (M1 > REPEAT_PERIOD) ? M1 : REPEAT_PERIOD;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_REL} state_t;

  state_t          state;
  logic [RW-1:0]   r;
  logic [SW-1:0]   sc;
  logic [COLS-1:0] col_p0, col_p1;
  logic [NK-1:0]   snap;
  logic [NK-1:0]   cur;
  logic [NK-1:0]   pressed;
  logic [1:0]      npc;
  logic [KW-1:0]   f_idx;
  logic [KW-1:0]   cand;
  logic [CW-1:0]   cnt, rep;
  logic [CW-1:0]   cnt_inc, rep_inc, rep_tgt;
  logic            first_rep;
  logic            slot_end, frame_end;
  logic            n_one, n_multi, cand_down;

  assign slot_end  = (sc == SW'(SETTLE_CYC - 1));
  assign frame_end = slot_end && (r == RW'(ROWS - 1));

  // Row drive decoded from the current row index: exactly one line low.
  always_comb begin
    row    = '1;
    row[r] = 1'b0;
  end

  // Slot and row counters: each row is held for SETTLE_CYC clocks, then wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc <= '0;
      r  <= '0;
    end else if (slot_end) begin
      sc <= '0;
      r  <= (r == RW'(ROWS - 1)) ? '0 : r + 1'b1;
    end else begin
      sc <= sc + 1'b1;
    end
  end

  // Two-flop column synchroniser; the snapshot keeps raw active-low levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_p0 <= '1;
      col_p1 <= '1;
      snap   <= '1;
    end else begin
      col_p0 <= col;
      col_p1 <= col_p0;
      if (slot_end) snap[r*COLS +: COLS] <= col_p1;
    end
  end

  // Frame view with the row being sampled this clock merged in, so the last
  // row of a frame is evaluated on the same edge it is captured.
  always_comb begin
    cur                  = snap;
    cur[r*COLS +: COLS]  = col_p1;
    pressed              = ~cur;
    npc                  = 2'd0;
    f_idx                = '0;
    for (int i = 0; i < NK; i++) begin
      if (pressed[i]) begin
        if (npc != 2'd2) npc = npc + 2'd1;
        f_idx = KW'(i);
      end
    end
  end

  assign n_one     = (npc == 2'd1);
  assign n_multi   = (npc == 2'd2);
  assign cand_down = pressed[cand];
  assign cnt_inc   = cnt + 1'b1;
  assign rep_inc   = rep + 1'b1;
  assign rep_tgt   = first_rep ? CW'(REPEAT_DELAY) : CW'(REPEAT_PERIOD);

  // Debounce / hold / repeat FSM, advanced once per frame; outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cand        <= '0;
      cnt         <= '0;
      rep         <= '0;
      first_rep   <= 1'b1;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      key_held    <= 1'b0;
      multi_key   <= 1'b0;
    end else begin
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      if (frame_end) begin
        multi_key <= n_multi;
        case (state)
          IDLE: begin
            if (n_one) begin
              cand <= f_idx;
              if (DEBOUNCE_FRAMES == 1) begin
                key_valid <= 1'b1;
                key_code  <= f_idx;
                key_held  <= 1'b1;
                rep       <= '0;
                first_rep <= 1'b1;
                state     <= HELD;
              end else begin
                cnt   <= CW'(1);
                state <= DEB_PRESS;
              end
            end
          end
          DEB_PRESS: begin
            if (n_one && (f_idx == cand)) begin
              if (cnt_inc == CW'(DEBOUNCE_FRAMES)) begin
                key_valid <= 1'b1;
                key_code  <= cand;
                key_held  <= 1'b1;
                rep       <= '0;
                first_rep <= 1'b1;
                state     <= HELD;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              state <= IDLE;
            end
          end
          HELD: begin
            if (cand_down) begin
              if (REPEAT_EN != 0) begin
                if (rep_inc == rep_tgt) begin
                  key_valid <= 1'b1;
                  rep       <= '0;
                  first_rep <= 1'b0;
                end else begin
                  rep <= rep_inc;
                end
              end
            end else if (DEBOUNCE_FRAMES == 1) begin
              key_release <= 1'b1;
              key_held    <= 1'b0;
              state       <= IDLE;
            end else begin
              cnt   <= CW'(1);
              state <= DEB_REL;
            end
          end
          DEB_REL: begin
            if (cand_down) begin
              state <= HELD;
            end else if (cnt_inc == CW'(DEBOUNCE_FRAMES)) begin
              key_release <= 1'b1;
              key_held    <= 1'b0;
              state       <= IDLE;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner. A behavioural keypad
// model turns a pressed-key vector into column levels for the driven row.
// Instance 0 has auto-repeat off, instance 1 has it on (delay 5, period 2).
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] keys = '0;
  logic [3:0]  row0, row1, col0, col1, code0, code1;
  logic        v0, v1, rl0, rl1, h0, h1, m0, m1;

  int checks = 0;
  int errors = 0;
  int nv0 = 0, nv1 = 0, nr0 = 0, nr1 = 0;

  typedef struct packed {
    logic [15:0] keys;
    logic        v;
    logic        rl;
    logic        h;
    logic        m;
    logic [3:0]  code;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  function automatic logic [3:0] colmodel(input logic [3:0] rw, input logic [15:0] k);
    logic [3:0] c;
    c = '1;
    for (int rr = 0; rr < 4; rr++)
      if (!rw[rr])
        for (int cc = 0; cc < 4; cc++)
          if (k[rr*4+cc]) c[cc] = 1'b0;
    return c;
  endfunction

  assign col0 = colmodel(row0, keys);
  assign col1 = colmodel(row1, keys);

  keypad_scanner #(.ROWS(4), .COLS(4), .SETTLE_CYC(4), .DEBOUNCE_FRAMES(3),
                   .REPEAT_EN(0), .REPEAT_DELAY(5), .REPEAT_PERIOD(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .row(row0), .col(col0), .key_code(code0),
    .key_valid(v0), .key_release(rl0), .key_held(h0), .multi_key(m0));

  keypad_scanner #(.ROWS(4), .COLS(4), .SETTLE_CYC(4), .DEBOUNCE_FRAMES(3),
                   .REPEAT_EN(1), .REPEAT_DELAY(5), .REPEAT_PERIOD(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .row(row1), .col(col1), .key_code(code1),
    .key_valid(v1), .key_release(rl1), .key_held(h1), .multi_key(m1));

  // Pulse counters: a pulse wider than one clock inflates the totals.
  always @(negedge clk) begin
    if (v0)  nv0 <= nv0 + 1;
    if (v1)  nv1 <= nv1 + 1;
    if (rl0) nr0 <= nr0 + 1;
    if (rl1) nr1 <= nr1 + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev0, input logic ev1, input logic erl,
                         input logic eh, input logic em, input logic [3:0] ecode);
    chk({tag, " valid0"},   32'(v0),    32'(ev0));
    chk({tag, " valid1"},   32'(v1),    32'(ev1));
    chk({tag, " release0"}, 32'(rl0),   32'(erl));
    chk({tag, " release1"}, 32'(rl1),   32'(erl));
    chk({tag, " held0"},    32'(h0),    32'(eh));
    chk({tag, " held1"},    32'(h1),    32'(eh));
    chk({tag, " multi0"},   32'(m0),    32'(em));
    chk({tag, " multi1"},   32'(m1),    32'(em));
    chk({tag, " code0"},    32'(code0), 32'(ecode));
    chk({tag, " code1"},    32'(code1), 32'(ecode));
  endtask

  // One full frame: 16 clocks, sampled 1 time unit after the evaluating edge.
  task automatic frame();
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [15:0] k, input logic v, input logic rl, input logic h,
                     input logic m, input logic [3:0] code);
    vec_t e;
    e.keys = k; e.v = v; e.rl = rl; e.h = h; e.m = m; e.code = code;
    tbl.push_back(e);
  endtask

  initial begin
    logic [3:0] er;

    // keys, valid, release, held, multi, code
    add(16'h0200, 0, 0, 0, 0, 4'd0);   // key 9 (row 2, col 1)
    add(16'h0200, 0, 0, 0, 0, 4'd0);
    add(16'h0200, 1, 0, 1, 0, 4'd9);
    add(16'h0200, 0, 0, 1, 0, 4'd9);
    add(16'h0000, 0, 0, 1, 0, 4'd9);
    add(16'h0000, 0, 0, 1, 0, 4'd9);
    add(16'h0000, 0, 1, 0, 0, 4'd9);
    add(16'h0020, 0, 0, 0, 0, 4'd9);   // key 5 bounce
    add(16'h0020, 0, 0, 0, 0, 4'd9);
    add(16'h0000, 0, 0, 0, 0, 4'd9);
    add(16'h0020, 0, 0, 0, 0, 4'd9);
    add(16'h0020, 0, 0, 0, 0, 4'd9);
    add(16'h0020, 1, 0, 1, 0, 4'd5);
    add(16'h0020, 0, 0, 1, 0, 4'd5);
    add(16'h0000, 0, 0, 1, 0, 4'd5);
    add(16'h0000, 0, 0, 1, 0, 4'd5);
    add(16'h0000, 0, 1, 0, 0, 4'd5);
    add(16'h8001, 0, 0, 0, 1, 4'd5);   // keys 0 and 15 from idle
    add(16'h8001, 0, 0, 0, 1, 4'd5);
    add(16'h0001, 0, 0, 0, 0, 4'd5);
    add(16'h0001, 0, 0, 0, 0, 4'd5);
    add(16'h0001, 1, 0, 1, 0, 4'd0);
    add(16'h0000, 0, 0, 1, 0, 4'd0);
    add(16'h0000, 0, 0, 1, 0, 4'd0);
    add(16'h0000, 0, 1, 0, 0, 4'd0);
    add(16'h0010, 0, 0, 0, 0, 4'd0);   // hold 4, then add 7
    add(16'h0010, 0, 0, 0, 0, 4'd0);
    add(16'h0010, 1, 0, 1, 0, 4'd4);
    add(16'h0090, 0, 0, 1, 1, 4'd4);
    add(16'h0090, 0, 0, 1, 1, 4'd4);
    add(16'h0080, 0, 0, 1, 0, 4'd4);
    add(16'h0080, 0, 0, 1, 0, 4'd4);
    add(16'h0080, 0, 1, 0, 0, 4'd4);
    add(16'h0080, 0, 0, 0, 0, 4'd4);
    add(16'h0080, 0, 0, 0, 0, 4'd4);
    add(16'h0080, 1, 0, 1, 0, 4'd7);
    add(16'h0000, 0, 0, 1, 0, 4'd7);
    add(16'h0000, 0, 0, 1, 0, 4'd7);
    add(16'h0000, 0, 1, 0, 0, 4'd7);
    add(16'h0200, 0, 0, 0, 0, 4'd7);   // release bounce back into held
    add(16'h0200, 0, 0, 0, 0, 4'd7);
    add(16'h0200, 1, 0, 1, 0, 4'd9);
    add(16'h0000, 0, 0, 1, 0, 4'd9);
    add(16'h0200, 0, 0, 1, 0, 4'd9);
    add(16'h0000, 0, 0, 1, 0, 4'd9);
    add(16'h0000, 0, 0, 1, 0, 4'd9);
    add(16'h0000, 0, 1, 0, 0, 4'd9);

    // Reset state
    #12;
    chk("reset row0", 32'(row0), 32'(4'b1110));
    chk("reset row1", 32'(row1), 32'(4'b1110));
    chk_out("reset", 0, 0, 0, 0, 0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Row rotation over the first (empty) frame
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      er = 4'b1111;
      er[(k/4)%4] = 1'b0;
      chk($sformatf("scan row k%0d", k), 32'(row0), 32'(er));
    end
    chk_out("idle frame", 0, 0, 0, 0, 0, 4'd0);

    // Table of frame-aligned vectors
    for (int i = 0; i < tbl.size(); i++) begin
      keys = tbl[i].keys;
      frame();
      chk_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].v, tbl[i].rl, tbl[i].h, tbl[i].m,
              tbl[i].code);
    end

    // Auto-repeat: key 10 accepted, then held 12 frames
    keys = 16'h0400;
    frame(); chk_out("rep deb1", 0, 0, 0, 0, 0, 4'd9);
    frame(); chk_out("rep deb2", 0, 0, 0, 0, 0, 4'd9);
    frame(); chk_out("rep accept", 1, 1, 0, 1, 0, 4'd10);
    for (int k = 1; k <= 12; k++) begin
      frame();
      chk_out($sformatf("rep k%0d", k), 0, (k == 5 || k == 7 || k == 9 || k == 11), 0, 1, 0,
              4'd10);
    end

    // Reset while held
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midreset row0", 32'(row0), 32'(4'b1110));
    chk("midreset row1", 32'(row1), 32'(4'b1110));
    chk_out("midreset", 0, 0, 0, 0, 0, 4'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    frame(); chk_out("post1", 0, 0, 0, 0, 0, 4'd0);
    frame(); chk_out("post2", 0, 0, 0, 0, 0, 4'd0);
    frame(); chk_out("post3", 1, 1, 0, 1, 0, 4'd10);
    keys = 16'h0000;
    frame(); chk_out("postrel1", 0, 0, 0, 1, 0, 4'd10);
    frame(); chk_out("postrel2", 0, 0, 0, 1, 0, 4'd10);
    frame(); chk_out("postrel3", 0, 0, 1, 0, 0, 4'd10);

    // Pulse totals (also catch stretched pulses and a release on reset)
    @(negedge clk);
    #1;
    chk("total valid0",   32'(nv0), 32'd8);
    chk("total valid1",   32'(nv1), 32'd12);
    chk("total release0", 32'(nr0), 32'd7);
    chk("total release1", 32'(nr1), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
